// File: rtl/hsv_core_dmem_arbiter_if.sv
// Single-beat AXI bundle used on both sides of the dmem arbiter.
// Modport s faces a requester; modport m faces the shared downstream slave.
interface axib_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int IW = 4
);
  logic          arvalid, arready;
  logic [AW-1:0] araddr;
  logic [IW-1:0] arid;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          rvalid, rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          awvalid, awready;
  logic [AW-1:0] awaddr;
  logic [IW-1:0] awid;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          wvalid, wready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          bvalid, bready;
  logic [1:0]    bresp;

  modport s (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
           awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
  modport m (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
           awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/hsv_core_dmem_arbiter.sv
// Two-requester arbiter for the shared dmem AXI port. Read and write paths arbitrate
// independently; in-order owner FIFOs steer R and B back to the issuing requester.
module hsv_core_dmem_owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic owner_i,
  input  logic pop_i,
  output logic owner_o,
  output logic empty_o,
  output logic full_o
);
  localparam int PW = $clog2(DEPTH);
  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wp_q, rp_q;
  logic [PW:0]      cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wp_q] <= owner_i;
        wp_q        <= wp_q + 1'b1;
      end
      if (pop_i) rp_q <= rp_q + 1'b1;
      if (push_i && !pop_i)      cnt_q <= cnt_q + 1'b1;
      else if (pop_i && !push_i) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign owner_o = mem_q[rp_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
endmodule

module hsv_core_dmem_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter bit FIXED_PRIORITY  = 1'b0
) (
  input  logic clk_core,
  input  logic rst_core,
  axib_if.s    s0,
  axib_if.s    s1,
  axib_if.m    m,
  output logic rd_idle,
  output logic wr_idle
);
  typedef enum logic [1:0] {RD_IDLE, RD_S0, RD_S1} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_S0, WR_S1} wr_state_e;

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;
  logic rd_prio_q, rd_prio_d, wr_prio_q, wr_prio_d;  // 1 = s1 wins the next tie
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic rf_head, rf_empty, rf_full, wf_head, wf_empty, wf_full;
  logic rd_s0, rd_s1, wr_s0, wr_s1;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs, wr_fin, rd_pick1, wr_pick1;

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      rd_state_q <= RD_IDLE;
      wr_state_q <= WR_IDLE;
      rd_prio_q  <= 1'b0;
      wr_prio_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_prio_q  <= rd_prio_d;
      wr_prio_q  <= wr_prio_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  assign rd_s0    = (rd_state_q == RD_S0);
  assign rd_s1    = (rd_state_q == RD_S1);
  assign wr_s0    = (wr_state_q == WR_S0);
  assign wr_s1    = (wr_state_q == WR_S1);
  assign rd_pick1 = s1.arvalid & (~s0.arvalid | (!FIXED_PRIORITY && rd_prio_q));
  assign wr_pick1 = s1.awvalid & (~s0.awvalid | (!FIXED_PRIORITY && wr_prio_q));
  assign ar_hs    = m.arvalid & m.arready;
  assign r_hs     = m.rvalid & m.rready;
  assign aw_hs    = m.awvalid & m.awready;
  assign w_hs     = m.wvalid & m.wready;
  assign b_hs     = m.bvalid & m.bready;
  assign wr_fin   = (aw_done_q | aw_hs) & (w_done_q | w_hs);

  always_comb begin
    rd_state_d = rd_state_q;
    rd_prio_d  = rd_prio_q;
    case (rd_state_q)
      RD_IDLE: if ((s0.arvalid | s1.arvalid) & ~rf_full) rd_state_d = rd_pick1 ? RD_S1 : RD_S0;
      RD_S0, RD_S1: if (ar_hs) begin
        rd_state_d = RD_IDLE;
        rd_prio_d  = ~rd_s1;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_prio_d  = wr_prio_q;
    aw_done_d  = aw_done_q | aw_hs;
    w_done_d   = w_done_q | w_hs;
    case (wr_state_q)
      WR_IDLE: if ((s0.awvalid | s1.awvalid) & ~wf_full) wr_state_d = wr_pick1 ? WR_S1 : WR_S0;
      WR_S0, WR_S1: begin
        if (aw_hs) wr_prio_d = ~wr_s1;
        if (wr_fin) begin
          wr_state_d = WR_IDLE;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    m.arvalid  = (rd_s0 & s0.arvalid) | (rd_s1 & s1.arvalid);
    m.araddr   = rd_s1 ? s1.araddr  : s0.araddr;
    m.arid     = rd_s1 ? s1.arid    : s0.arid;
    m.arlen    = rd_s1 ? s1.arlen   : s0.arlen;
    m.arsize   = rd_s1 ? s1.arsize  : s0.arsize;
    m.arburst  = rd_s1 ? s1.arburst : s0.arburst;
    s0.arready = rd_s0 & m.arready;
    s1.arready = rd_s1 & m.arready;
    // with nothing outstanding a stray R is left unacknowledged
    m.rready   = ~rf_empty & (rf_head ? s1.rready : s0.rready);
    s0.rvalid  = ~rf_empty & ~rf_head & m.rvalid;
    s1.rvalid  = ~rf_empty &  rf_head & m.rvalid;
    s0.rdata   = m.rdata;
    s1.rdata   = m.rdata;
    s0.rresp   = m.rresp;
    s1.rresp   = m.rresp;
  end

  always_comb begin
    m.awvalid  = ((wr_s0 & s0.awvalid) | (wr_s1 & s1.awvalid)) & ~aw_done_q;
    m.wvalid   = ((wr_s0 & s0.wvalid)  | (wr_s1 & s1.wvalid))  & ~w_done_q;
    m.awaddr   = wr_s1 ? s1.awaddr  : s0.awaddr;
    m.awid     = wr_s1 ? s1.awid    : s0.awid;
    m.awlen    = wr_s1 ? s1.awlen   : s0.awlen;
    m.awsize   = wr_s1 ? s1.awsize  : s0.awsize;
    m.awburst  = wr_s1 ? s1.awburst : s0.awburst;
    m.wdata    = wr_s1 ? s1.wdata   : s0.wdata;
    m.wstrb    = wr_s1 ? s1.wstrb   : s0.wstrb;
    s0.awready = wr_s0 & m.awready & ~aw_done_q;
    s1.awready = wr_s1 & m.awready & ~aw_done_q;
    s0.wready  = wr_s0 & m.wready & ~w_done_q;
    s1.wready  = wr_s1 & m.wready & ~w_done_q;
    m.bready   = ~wf_empty & (wf_head ? s1.bready : s0.bready);
    s0.bvalid  = ~wf_empty & ~wf_head & m.bvalid;
    s1.bvalid  = ~wf_empty &  wf_head & m.bvalid;
    s0.bresp   = m.bresp;
    s1.bresp   = m.bresp;
  end

  hsv_core_dmem_owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_rd_fifo (
    .clk_i(clk_core), .rst_i(rst_core), .push_i(ar_hs), .owner_i(rd_s1), .pop_i(r_hs),
    .owner_o(rf_head), .empty_o(rf_empty), .full_o(rf_full)
  );

  hsv_core_dmem_owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_wr_fifo (
    .clk_i(clk_core), .rst_i(rst_core), .push_i(aw_hs), .owner_i(wr_s1), .pop_i(b_hs),
    .owner_o(wf_head), .empty_o(wf_empty), .full_o(wf_full)
  );

  assign rd_idle = (rd_state_q == RD_IDLE) & rf_empty;
  assign wr_idle = (wr_state_q == WR_IDLE) & wf_empty;
endmodule
